// File: rtl/seg_display_ctrl.sv
// Six-digit multiplexed seven-segment controller: shift-add-3 binary-to-BCD conversion,
// leading-zero blanking with sign placement, and a continuously running digit scan.
module seg_display_ctrl #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        en,
  input  logic        sign,
  input  logic        load,
  output logic        busy,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [4:0]       iter_q, iter_d;
  logic [19:0]      bin_q, bin_d;
  logic [23:0]      bcd_q, bcd_d;
  logic [23:0]      bcd_adj;
  logic [5:0]       sh_point_q, sh_point_d;
  logic             sh_sign_q, sh_sign_d;
  logic             sh_en_q, sh_en_d;
  logic [23:0]      disp_bcd_q, disp_bcd_d;
  logic [5:0]       disp_point_q, disp_point_d;
  logic             disp_sign_q, disp_sign_d;
  logic             disp_en_q, disp_en_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       dig_q, dig_d;
  logic [5:0]       seg_sel_q, seg_sel_d;
  logic [7:0]       seg_led_q, seg_led_d;
  logic [2:0]       msd, pmax, lim;
  logic [3:0]       nib;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end
  end

  // Conversion FSM; display registers change only in DONE so the scan never sees partial results.
  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    sh_point_d   = sh_point_q;
    sh_sign_d    = sh_sign_q;
    sh_en_d      = sh_en_q;
    disp_bcd_d   = disp_bcd_q;
    disp_point_d = disp_point_q;
    disp_sign_d  = disp_sign_q;
    disp_en_d    = disp_en_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d      = (data > 20'd999999) ? 20'd999999 : data;
          bcd_d      = '0;
          iter_d     = '0;
          sh_point_d = point;
          sh_sign_d  = sign;
          sh_en_d    = en;
          state_d    = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj[22:0], bin_q, 1'b0};
        iter_d         = iter_q + 5'd1;
        if (iter_q == 5'd19) state_d = DONE;
      end
      DONE: begin
        disp_bcd_d   = bcd_q;
        disp_point_d = sh_point_q;
        disp_sign_d  = sh_sign_q;
        disp_en_d    = sh_en_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    dig_d = dig_q;
    if (div_q == DIV_LAST) dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
  end

  // Blanking limit is the larger of the top nonzero digit and the top lit decimal point.
  always_comb begin
    msd  = 3'd0;
    pmax = 3'd0;
    nib  = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (disp_bcd_q[i*4 +: 4] != 4'd0) msd = 3'(i);
      if (disp_point_q[i]) pmax = 3'(i);
      if (dig_q == 3'(i)) nib = disp_bcd_q[i*4 +: 4];
    end
    lim = (msd > pmax) ? msd : pmax;
  end

  always_comb begin
    seg_sel_d = 6'b111111;
    seg_led_d = 8'hFF;
    if (disp_en_q) begin
      seg_sel_d = ~(6'b000001 << dig_q);
      if (dig_q > lim) begin
        seg_led_d = (disp_sign_q && dig_q == lim + 3'd1) ? 8'hBF : 8'hFF;
      end else begin
        seg_led_d = seg_code(nib) & (disp_point_q[dig_q] ? 8'h7F : 8'hFF);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      iter_q       <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      sh_point_q   <= '0;
      sh_sign_q    <= 1'b0;
      sh_en_q      <= 1'b0;
      disp_bcd_q   <= '0;
      disp_point_q <= '0;
      disp_sign_q  <= 1'b0;
      disp_en_q    <= 1'b0;
      div_q        <= '0;
      dig_q        <= '0;
      seg_sel_q    <= 6'b111111;
      seg_led_q    <= 8'hFF;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      sh_point_q   <= sh_point_d;
      sh_sign_q    <= sh_sign_d;
      sh_en_q      <= sh_en_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_point_q <= disp_point_d;
      disp_sign_q  <= disp_sign_d;
      disp_en_q    <= disp_en_d;
      div_q        <= div_d;
      dig_q        <= dig_d;
      seg_sel_q    <= seg_sel_d;
      seg_led_q    <= seg_led_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign seg_sel = seg_sel_q;
  assign seg_led = seg_led_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: directed and random loads checked against a decimal-arithmetic model.
module tb_seg_display_ctrl;

  localparam int unsigned CLK_DIV = 4;

  logic        clk;
  logic        rst_n;
  logic [19:0] data;
  logic [5:0]  point;
  logic        en;
  logic        sign;
  logic        load;
  logic        busy;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;

  int checks = 0;
  int errors = 0;
  int n;  // clock edges since reset release

  seg_display_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (data),
    .point   (point),
    .en      (en),
    .sign    (sign),
    .load    (load),
    .busy    (busy),
    .seg_sel (seg_sel),
    .seg_led (seg_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  function automatic logic [7:0] digit_code(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] ref_code(input int unsigned raw, input logic [5:0] p,
                                          input logic s, input int idx);
    int unsigned v;
    int unsigned div;
    int d[6];
    int msd;
    int ph;
    int lim;
    v   = (raw > 999999) ? 999999 : raw;
    div = 1;
    msd = 0;
    ph  = 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'((v / div) % 10);
      div  = div * 10;
      if (d[i] != 0) msd = i;
      if (p[i]) ph = i;
    end
    lim = (msd > ph) ? msd : ph;
    if (idx > lim) return (s && idx == lim + 1) ? 8'hBF : 8'hFF;
    return digit_code(d[idx]) & (p[idx] ? 8'h7F : 8'hFF);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  // Outputs after edge n reflect digit index and display contents after edge n-1.
  task automatic check_scan(input string tag, input int unsigned v, input logic [5:0] p,
                            input logic s, input logic e);
    int idx;
    logic [7:0] exp_sel;
    idx     = ((n - 1) / CLK_DIV) % 6;
    exp_sel = e ? {2'b00, ~(6'b000001 << idx)} : 8'h3F;
    chk({tag, "_sel"}, {2'b00, seg_sel}, exp_sel);
    chk({tag, "_led"}, seg_led, e ? ref_code(v, p, s, idx) : 8'hFF);
  endtask

  task automatic check_frame(input string tag, input int unsigned v, input logic [5:0] p,
                             input logic s, input logic e);
    for (int k = 0; k < 6 * CLK_DIV; k++) begin
      @(negedge clk);
      check_scan(tag, v, p, s, e);
    end
  endtask

  // Issue one load from IDLE, check busy through the conversion, then check a full frame.
  task automatic load_check(input string tag, input int unsigned v, input logic [5:0] p,
                            input logic s, input logic e);
    @(negedge clk);
    data  = 20'(v);
    point = p;
    sign  = s;
    en    = e;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, {7'd0, busy}, (k <= 20) ? 8'd1 : 8'd0);
    end
    check_frame(tag, v, p, s, e);
  endtask

  initial begin
    data  = '0;
    point = '0;
    en    = 1'b0;
    sign  = 1'b0;
    load  = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel", {2'b00, seg_sel}, 8'h3F);
    chk("rst_led", seg_led, 8'hFF);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("dark", 0, 6'd0, 1'b0, 1'b0);

    load_check("d123456", 123456, 6'b000000, 1'b0, 1'b1);
    load_check("d5sign", 5, 6'b000100, 1'b1, 1'b1);
    load_check("clamp", 1000000, 6'b000000, 1'b0, 1'b1);
    load_check("zero", 0, 6'b000000, 1'b0, 1'b1);

    // Load held high for 30 edges: only edges 0 and 22 may capture.
    @(negedge clk);
    data  = 20'd42;
    point = '0;
    sign  = 1'b0;
    en    = 1'b1;
    load  = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      if (k == 0) data = 20'd7;
      if (k == 29) load = 1'b0;
      chk("spam_busy", {7'd0, busy}, ((k <= 20) || (k >= 22 && k <= 42)) ? 8'd1 : 8'd0);
      if (k >= 22 && k <= 43) check_scan("spam42", 42, 6'd0, 1'b0, 1'b1);
      else if (k >= 44) check_scan("spam7", 7, 6'd0, 1'b0, 1'b1);
    end

    load_check("en0", 888, 6'b000001, 1'b1, 1'b0);
    load_check("en1", 31, 6'b000010, 1'b0, 1'b1);

    // Reset in the middle of a conversion.
    load_check("pre_rst", 987654, 6'b001000, 1'b0, 1'b1);
    @(negedge clk);
    data = 20'd111;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", {2'b00, seg_sel}, 8'h3F);
    chk("mid_rst_led", seg_led, 8'hFF);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("post_rst_busy", {7'd0, busy}, 8'd0);
      check_scan("post_rst", 0, 6'd0, 1'b0, 1'b0);
    end
    load_check("after_rst", 2024, 6'b000000, 1'b1, 1'b1);

    for (int r = 0; r < 8; r++) begin
      load_check("rand", $urandom_range(0, 1048575), 6'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
